// File: rtl/ex_hazard_ctrl.sv
// Hazard controller for the 5-stage RV32I core: EX operand forwarding, load-use stall,
// taken-branch flush of IF/ID and ID/EX, and saturating stall/flush event counters.
module ex_hazard_ctrl #(
    parameter int unsigned CNT_W  = 16,
    parameter bit          EN_FWD = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [31:0]      id_inst,
    input  logic             ex_taken,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic             stall,
    output logic             flush_ifid,
    output logic             flush_idex,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       use1;
        logic       use2;
        logic [4:0] rd;
        logic       we;
        logic       ld;
    } trk_t;

    localparam logic [1:0] SEL_RF = 2'b00;
    localparam logic [1:0] SEL_MA = 2'b01;
    localparam logic [1:0] SEL_WB = 2'b10;

    trk_t id_dec;
    trk_t ex_p0, ma_p1, wb_p2;
    logic hazard, stall_i;
    logic [1:0] fwd_a, fwd_b;

    function automatic logic raw_match(input trk_t prod, input logic [4:0] rs, input logic use_rs);
        return use_rs & prod.we & (prod.rd == rs);
    endfunction

    function automatic logic [1:0] fwd_sel(input trk_t ma, input trk_t wb, input logic [4:0] rs,
                                           input logic use_rs);
        if (raw_match(ma, rs, use_rs))
            return SEL_MA;
        else if (raw_match(wb, rs, use_rs))
            return SEL_WB;
        return SEL_RF;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        return (cnt == {CNT_W{1'b1}}) ? cnt : cnt + 1'b1;
    endfunction

    always_comb begin
        id_dec     = '0;
        id_dec.rs1 = id_inst[19:15];
        id_dec.rs2 = id_inst[24:20];
        id_dec.rd  = id_inst[11:7];
        if (id_valid) begin
            case (id_inst[6:0])
                7'b0110011: begin id_dec.use1 = 1'b1; id_dec.use2 = 1'b1; id_dec.we = 1'b1; end
                7'b0010011: begin id_dec.use1 = 1'b1; id_dec.we = 1'b1; end
                7'b0000011: begin id_dec.use1 = 1'b1; id_dec.we = 1'b1; id_dec.ld = 1'b1; end
                7'b0100011: begin id_dec.use1 = 1'b1; id_dec.use2 = 1'b1; end
                7'b1100011: begin id_dec.use1 = 1'b1; id_dec.use2 = 1'b1; end
                7'b1101111: id_dec.we = 1'b1;
                7'b1100111: begin id_dec.use1 = 1'b1; id_dec.we = 1'b1; end
                7'b0110111: id_dec.we = 1'b1;
                7'b0010111: id_dec.we = 1'b1;
                default:    ;
            endcase
        end
        // x0 is never a real producer, so a use of x0 can never match
        if (id_dec.rd == 5'd0) begin
            id_dec.we = 1'b0;
            id_dec.ld = 1'b0;
        end
    end

    always_comb begin
        if (EN_FWD) begin
            hazard = ex_p0.ld & (raw_match(ex_p0, id_dec.rs1, id_dec.use1) |
                                 raw_match(ex_p0, id_dec.rs2, id_dec.use2));
            fwd_a  = fwd_sel(ma_p1, wb_p2, ex_p0.rs1, ex_p0.use1);
            fwd_b  = fwd_sel(ma_p1, wb_p2, ex_p0.rs2, ex_p0.use2);
        end else begin
            hazard = raw_match(ex_p0, id_dec.rs1, id_dec.use1) | raw_match(ex_p0, id_dec.rs2, id_dec.use2) |
                     raw_match(ma_p1, id_dec.rs1, id_dec.use1) | raw_match(ma_p1, id_dec.rs2, id_dec.use2) |
                     raw_match(wb_p2, id_dec.rs1, id_dec.use1) | raw_match(wb_p2, id_dec.rs2, id_dec.use2);
            fwd_a  = SEL_RF;
            fwd_b  = SEL_RF;
        end
        // a taken branch discards the ID instruction, so its hazard is moot
        stall_i = hazard & ~ex_taken;
    end

    always_comb begin
        fwd_a_sel  = rst ? SEL_RF : fwd_a;
        fwd_b_sel  = rst ? SEL_RF : fwd_b;
        stall      = stall_i & ~rst;
        flush_ifid = ex_taken & ~rst;
        flush_idex = ex_taken & ~rst;
    end

    // ID -> EX(p0) -> MA(p1) -> WB(p2)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_p0     <= '0;
            ma_p1     <= '0;
            wb_p2     <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            ex_p0 <= (stall_i | ex_taken) ? '0 : id_dec;
            ma_p1 <= ex_p0;
            wb_p2 <= ma_p1;
            if (stall_i)
                stall_cnt <= sat_inc(stall_cnt);
            if (ex_taken)
                flush_cnt <= sat_inc(flush_cnt);
        end
    end

    logic unused_bits;
    assign unused_bits = ^{id_inst[31:25], id_inst[14:12], ma_p1, wb_p2};

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Directed bench for ex_hazard_ctrl: forwarding, load-use stall, flush, no-forward mode,
// reset during a stall and counter saturation (narrow counter instance).
module tb_ex_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [31:0] id_inst;
    logic        ex_taken;

    logic [1:0]  fa, fb, fa_n, fb_n, fa_s, fb_s;
    logic        st, fi, fx, st_n, fi_n, fx_n, st_s, fi_s, fx_s;
    logic [15:0] scnt, fcnt, scnt_n, fcnt_n;
    logic [3:0]  scnt_s, fcnt_s;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ex_hazard_ctrl #(.CNT_W(16), .EN_FWD(1'b1)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_inst(id_inst), .ex_taken(ex_taken),
        .fwd_a_sel(fa), .fwd_b_sel(fb), .stall(st), .flush_ifid(fi), .flush_idex(fx),
        .stall_cnt(scnt), .flush_cnt(fcnt));

    ex_hazard_ctrl #(.CNT_W(16), .EN_FWD(1'b0)) dut_nf (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_inst(id_inst), .ex_taken(ex_taken),
        .fwd_a_sel(fa_n), .fwd_b_sel(fb_n), .stall(st_n), .flush_ifid(fi_n), .flush_idex(fx_n),
        .stall_cnt(scnt_n), .flush_cnt(fcnt_n));

    ex_hazard_ctrl #(.CNT_W(4), .EN_FWD(1'b1)) dut_sat (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_inst(id_inst), .ex_taken(ex_taken),
        .fwd_a_sel(fa_s), .fwd_b_sel(fb_s), .stall(st_s), .flush_ifid(fi_s), .flush_idex(fx_s),
        .stall_cnt(scnt_s), .flush_cnt(fcnt_s));

    function automatic logic [31:0] r_op(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
    endfunction
    function automatic logic [31:0] i_op(input logic [4:0] rd, input logic [4:0] rs1);
        return {12'd5, rs1, 3'b000, rd, 7'b0010011};
    endfunction
    function automatic logic [31:0] ld_op(input logic [4:0] rd, input logic [4:0] rs1);
        return {12'd0, rs1, 3'b010, rd, 7'b0000011};
    endfunction

    localparam logic [31:0] NOP = 32'h0000_0013;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [31:0] inst, input logic tk);
        id_valid = 1'b1;
        id_inst  = inst;
        ex_taken = tk;
        #2;
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        id_valid = 1'b0;
        id_inst  = NOP;
        ex_taken = 1'b0;
        adv();
        rst = 1'b0;
    endtask

    initial begin
        // outputs gated while in reset, even with live inputs
        rst = 1'b1; id_valid = 1'b1; id_inst = ld_op(5, 1); ex_taken = 1'b1;
        #2;
        check("rst_flush_ifid", 32'(fi), 0);
        check("rst_flush_idex", 32'(fx), 0);
        check("rst_stall_cnt", 32'(scnt), 0);
        check("rst_flush_cnt", 32'(fcnt), 0);
        adv();

        // load-use: lw x5,0(x1) ; add x6,x5,x2
        do_reset();
        drive(ld_op(5, 1), 1'b0);      check("lu_no_stall_first", 32'(st), 0); adv();
        drive(r_op(6, 5, 2), 1'b0);    check("lu_stall", 32'(st), 1);
        check("lu_fwd_a_lw_in_ex", 32'(fa), 0); adv();
        drive(r_op(6, 5, 2), 1'b0);    check("lu_stall_released", 32'(st), 0);
        check("lu_stall_cnt", 32'(scnt), 1); adv();
        drive(NOP, 1'b0);              check("lu_fwd_a_wb", 32'(fa), 2);
        check("lu_fwd_b", 32'(fb), 0); adv();

        // add x5,x1,x2 ; sub x7,x5,x5 -> both from MA
        do_reset();
        drive(r_op(5, 1, 2), 1'b0);    adv();
        drive(r_op(7, 5, 5), 1'b0);    check("alu_no_stall", 32'(st), 0); adv();
        drive(NOP, 1'b0);              check("alu_fwd_a_ma", 32'(fa), 1);
        check("alu_fwd_b_ma", 32'(fb), 1); adv();
        // add x5 ; nop ; or x8,x3,x5 -> rs2 from WB
        drive(r_op(5, 1, 2), 1'b0);    adv();
        drive(NOP, 1'b0);              adv();
        drive(r_op(8, 3, 5), 1'b0);    adv();
        drive(NOP, 1'b0);              check("or_fwd_b_wb", 32'(fb), 2);
        check("or_fwd_a_rf", 32'(fa), 0); adv();
        // addi x0 ; add x9,x0,x0 -> x0 never forwarded
        drive(i_op(0, 1), 1'b0);       adv();
        drive(r_op(9, 0, 0), 1'b0);    adv();
        drive(NOP, 1'b0);              check("x0_fwd_a", 32'(fa), 0);
        check("x0_fwd_b", 32'(fb), 0); adv();
        // x5 written in both MA and WB -> MA wins
        drive(r_op(5, 1, 2), 1'b0);    adv();
        drive(r_op(5, 2, 3), 1'b0);    adv();
        drive(r_op(10, 5, 1), 1'b0);   adv();
        drive(NOP, 1'b0);              check("prio_fwd_a_ma", 32'(fa), 1);
        check("prio_fwd_b_rf", 32'(fb), 0); adv();

        // load-use hazard coinciding with a taken branch
        do_reset();
        drive(ld_op(5, 1), 1'b0);      adv();
        drive(r_op(6, 5, 2), 1'b1);    check("tk_stall", 32'(st), 0);
        check("tk_flush_ifid", 32'(fi), 1);
        check("tk_flush_idex", 32'(fx), 1); adv();
        drive(NOP, 1'b0);              check("tk_flush_cnt", 32'(fcnt), 1);
        check("tk_stall_cnt", 32'(scnt), 0);
        check("tk_flush_ifid_off", 32'(fi), 0); adv();

        // no-forward mode: add x5,x1,x2 ; add x6,x5,x0 -> 3 stall cycles
        do_reset();
        drive(r_op(5, 1, 2), 1'b0);    check("nf_no_stall_first", 32'(st_n), 0); adv();
        drive(r_op(6, 5, 0), 1'b0);    check("nf_stall_1", 32'(st_n), 1);
        check("nf_fwd_a_1", 32'(fa_n), 0);
        check("fwd_alu_no_stall", 32'(st), 0); adv();
        drive(r_op(6, 5, 0), 1'b0);    check("nf_stall_2", 32'(st_n), 1);
        check("nf_fwd_a_2", 32'(fa_n), 0); adv();
        drive(r_op(6, 5, 0), 1'b0);    check("nf_stall_3", 32'(st_n), 1);
        check("nf_fwd_a_3", 32'(fa_n), 0); adv();
        drive(r_op(6, 5, 0), 1'b0);    check("nf_stall_done", 32'(st_n), 0);
        check("nf_stall_cnt", 32'(scnt_n), 3); adv();
        drive(NOP, 1'b0);              check("nf_fwd_a_consumer", 32'(fa_n), 0);
        check("nf_fwd_b_consumer", 32'(fb_n), 0); adv();

        // reset asserted during a stall
        do_reset();
        drive(ld_op(5, 1), 1'b0);      adv();
        drive(r_op(6, 5, 2), 1'b0);    adv();
        drive(ld_op(7, 1), 1'b0);      adv();
        drive(r_op(8, 7, 7), 1'b0);    check("rs_stall_before", 32'(st), 1);
        check("rs_cnt_before", 32'(scnt), 1);
        rst = 1'b1; ex_taken = 1'b1;   #1;
        check("rs_stall_gated", 32'(st), 0);
        check("rs_flush_gated", 32'(fi), 0);
        check("rs_cnt_cleared", 32'(scnt), 0);
        adv();
        rst = 1'b0; ex_taken = 1'b0;   #1;
        check("rs_empty_pipe", 32'(st), 0);
        check("rs_flush_cnt", 32'(fcnt), 0); adv();

        // counter saturation: lw x5,0(x5) held in ID stalls every other cycle
        do_reset();
        for (int i = 0; i < 40; i++) begin
            drive(ld_op(5, 5), 1'b0);
            adv();
        end
        check("sat_stall_cnt16", 32'(scnt), 20);
        check("sat_stall_cnt4", 32'(scnt_s), 15);
        for (int i = 0; i < 20; i++) begin
            drive(ld_op(5, 5), 1'b1);
            adv();
        end
        drive(NOP, 1'b0);
        check("sat_flush_cnt16", 32'(fcnt), 20);
        check("sat_flush_cnt4", 32'(fcnt_s), 15);
        check("sat_stall_hold16", 32'(scnt), 20);
        check("sat_stall_hold4", 32'(scnt_s), 15);
        adv();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
